// File: rtl/im_loader_if.sv
// Boot-loader bus: byte stream in, instruction-memory write port and status out.
interface im_loader_if #(
  parameter int unsigned AW = 10
);

  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          we;
  logic [AW-1:0] waddr;
  logic [31:0]   wpc;
  logic [31:0]   wdata;
  logic          busy;
  logic          done;
  logic          err;
  logic          cpu_hold;

  // Loader side: consumes the byte stream, drives the IM write port and status
  modport master (
    input  in_valid, in_data,
    output in_ready, we, waddr, wpc, wdata, busy, done, err, cpu_hold
  );

  // Environment side: byte source plus IM / CPU-reset consumers
  modport slave (
    output in_valid, in_data,
    input  in_ready, we, waddr, wpc, wdata, busy, done, err, cpu_hold
  );

endinterface

// File: rtl/im_loader.sv
// Instruction-memory loader: turns a big-endian length-prefixed byte stream
// into one-word IM write strobes and holds the CPU until the image is in.
module im_loader #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10,
  parameter logic [31:0] BASE  = 32'h0000_3000
) (
  input logic         clk,
  input logic         reset,
  im_loader_if.master bus
);

  // Word counter is one bit wider than the address so N == DEPTH is representable
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    LEN_HI,
    LEN_LO,
    WORD,
    LAST_WR,
    DONE,
    ERR
  } state_t;

  state_t        state;
  logic [15:0]   len;
  logic [1:0]    byte_cnt;
  logic [CW-1:0] word_cnt;
  logic [23:0]   shreg;

  logic          xfer_c;
  logic [15:0]   n_c;
  logic [31:0]   word_c;

  // Handshake, declared length as it completes, and the word the current byte finishes
  always_comb begin
    xfer_c = bus.in_valid && bus.in_ready;
    n_c    = {len[15:8], bus.in_data};
    word_c = {shreg, bus.in_data};
  end

  // Loader FSM with all outputs registered
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= LEN_HI;
      len          <= 16'd0;
      byte_cnt     <= 2'd0;
      word_cnt     <= '0;
      shreg        <= 24'd0;
      bus.in_ready <= 1'b1;
      bus.we       <= 1'b0;
      bus.waddr    <= '0;
      bus.wpc      <= BASE;
      bus.wdata    <= 32'd0;
      bus.busy     <= 1'b1;
      bus.done     <= 1'b0;
      bus.err      <= 1'b0;
      bus.cpu_hold <= 1'b1;
    end else begin
      bus.we <= 1'b0;
      case (state)
        LEN_HI: begin
          if (xfer_c) begin
            len[15:8] <= bus.in_data;
            state     <= LEN_LO;
          end
        end
        LEN_LO: begin
          if (xfer_c) begin
            len[7:0] <= bus.in_data;
            if (n_c == 16'd0) begin
              state        <= DONE;
              bus.in_ready <= 1'b0;
              bus.done     <= 1'b1;
              bus.busy     <= 1'b0;
              bus.cpu_hold <= 1'b0;
            end else if (32'(n_c) > DEPTH) begin
              state        <= ERR;
              bus.in_ready <= 1'b0;
              bus.err      <= 1'b1;
              bus.busy     <= 1'b0;
            end else begin
              state <= WORD;
            end
          end
        end
        WORD: begin
          if (xfer_c) begin
            shreg    <= word_c[23:0];
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              bus.we    <= 1'b1;
              bus.wdata <= word_c;
              bus.waddr <= word_cnt[AW-1:0];
              bus.wpc   <= BASE + 32'({word_cnt[AW-1:0], 2'b00});
              word_cnt  <= word_cnt + CW'(1);
              // Final word: stop accepting while its strobe is issued
              if ((16'(word_cnt) + 16'd1) == len) begin
                state        <= LAST_WR;
                bus.in_ready <= 1'b0;
              end
            end
          end
        end
        LAST_WR: begin
          state        <= DONE;
          bus.done     <= 1'b1;
          bus.busy     <= 1'b0;
          bus.cpu_hold <= 1'b0;
        end
        DONE: begin
          state <= DONE;
        end
        ERR: begin
          state <= ERR;
        end
        default: begin
          state <= LEN_HI;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_im_loader.sv
// Bench for im_loader: stream-level model predicts writes and status every cycle.
module tb_im_loader;

  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;
  localparam logic [31:0] BASE  = 32'h0000_3000;

  logic clk = 1'b0;
  logic reset;

  im_loader_if #(.AW(AW)) bus ();

  im_loader #(.DEPTH(DEPTH), .AW(AW), .BASE(BASE)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          idx;
    logic [31:0] word;
  } wr_t;

  // Stream model: bytes accepted so far, declared length, pending writes
  wr_t         expq[$];
  int          m_bytes;
  logic [15:0] m_len;
  logic [31:0] m_word;
  bit          m_zero;
  bit          m_err;
  // Owned by the compare process
  bit          m_fin;
  int          n_writes;

  logic [7:0] basic [10] = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05,
                             8'h00, 8'h00, 8'h00, 8'h0C};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    wr_t e;
    if (m_bytes == 0) begin
      m_len[15:8] = b;
    end else if (m_bytes == 1) begin
      m_len[7:0] = b;
      if (m_len == 16'd0) m_zero = 1'b1;
      else if (int'(m_len) > int'(DEPTH)) m_err = 1'b1;
    end else begin
      m_word = {m_word[23:0], b};
      if ((m_bytes - 2) % 4 == 3) begin
        e.idx  = (m_bytes - 2) / 4;
        e.word = m_word;
        expq.push_back(e);
      end
    end
    m_bytes++;
  endtask

  function automatic bit m_accepting();
    return (m_bytes < 2) || (!m_zero && !m_err && m_bytes < 2 + 4 * int'(m_len));
  endfunction

  // Per-cycle comparison of every output against the model
  initial begin
    bit  exp_done;
    wr_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_fin    = 1'b0;
        n_writes = 0;
      end else begin
        exp_done = m_zero || m_fin;
        chk("in_ready", 32'(bus.in_ready), 32'(m_accepting()));
        chk("done", 32'(bus.done), 32'(exp_done));
        chk("err", 32'(bus.err), 32'(m_err));
        chk("busy", 32'(bus.busy), 32'(!(exp_done || m_err)));
        chk("cpu_hold", 32'(bus.cpu_hold), 32'(!exp_done));
        chk("we", 32'(bus.we), 32'(expq.size() > 0));
        if (bus.we && expq.size() > 0) begin
          e = expq.pop_front();
          n_writes++;
          chk("waddr", 32'(bus.waddr), 32'(e.idx));
          chk("wdata", bus.wdata, e.word);
          chk("wpc", bus.wpc, BASE + 32'(e.idx * 4));
          if (e.idx == int'(m_len) - 1) m_fin = 1'b1;
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    expq.delete();
    m_bytes = 0;
    m_len   = 16'd0;
    m_word  = 32'd0;
    m_zero  = 1'b0;
    m_err   = 1'b0;
    #1;
    chk("rst_we", 32'(bus.we), 32'd0);
    chk("rst_waddr", 32'(bus.waddr), 32'd0);
    chk("rst_wpc", bus.wpc, 32'h0000_3000);
    chk("rst_wdata", bus.wdata, 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd1);
    chk("rst_cpu_hold", 32'(bus.cpu_hold), 32'd1);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Present one byte from a negedge until accepted; returns on the negedge after the transfer
  task automatic send(input logic [7:0] b, input int gap);
    int budget;
    bit ok;
    budget = 0;
    ok     = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!ok && budget < 20) begin
      if (bus.in_ready) begin
        @(posedge clk);
        model_byte(b);
        ok = 1'b1;
        @(negedge clk);
      end else begin
        @(negedge clk);
        budget++;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: byte %h not accepted within 20 cycles", b);
    end
    if (gap > 0) begin
      bus.in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  // Hold a byte on the bus for n cycles where no transfer may occur
  task automatic offer_ignored(input logic [7:0] b, input int n);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    repeat (n) begin
      chk("ignored_in_ready", 32'(bus.in_ready), 32'd0);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    // Basic load at one byte per cycle
    do_reset();
    for (int i = 0; i < 6; i++) send(basic[i], 0);
    chk("basic_we0", 32'(bus.we), 32'd1);
    chk("basic_waddr0", 32'(bus.waddr), 32'd0);
    chk("basic_wpc0", bus.wpc, 32'h0000_3000);
    chk("basic_wdata0", bus.wdata, 32'h2401_0005);
    for (int i = 6; i < 10; i++) send(basic[i], 0);
    bus.in_valid = 1'b0;
    chk("basic_we1", 32'(bus.we), 32'd1);
    chk("basic_waddr1", 32'(bus.waddr), 32'd1);
    chk("basic_wpc1", bus.wpc, 32'h0000_3004);
    chk("basic_wdata1", bus.wdata, 32'h0000_000C);
    chk("basic_ready_last", 32'(bus.in_ready), 32'd0);
    chk("basic_done_early", 32'(bus.done), 32'd0);
    @(negedge clk);
    chk("basic_done", 32'(bus.done), 32'd1);
    chk("basic_hold", 32'(bus.cpu_hold), 32'd0);
    chk("basic_waddr_hold", 32'(bus.waddr), 32'd1);
    offer_ignored(8'h55, 3);
    chk("basic_writes", 32'(n_writes), 32'd2);

    // Same stream with a one-cycle gap after every byte
    do_reset();
    for (int i = 0; i < 10; i++) send(basic[i], 1);
    repeat (3) @(negedge clk);
    chk("gap_done", 32'(bus.done), 32'd1);
    chk("gap_wdata_hold", bus.wdata, 32'h0000_000C);
    chk("gap_writes", 32'(n_writes), 32'd2);

    // Zero-length image
    do_reset();
    send(8'h00, 0);
    send(8'h00, 0);
    bus.in_valid = 1'b0;
    chk("zero_done", 32'(bus.done), 32'd1);
    chk("zero_ready", 32'(bus.in_ready), 32'd0);
    chk("zero_hold", 32'(bus.cpu_hold), 32'd0);
    repeat (2) @(negedge clk);
    chk("zero_writes", 32'(n_writes), 32'd0);

    // Oversize image (N = DEPTH + 1)
    do_reset();
    send(8'h04, 0);
    send(8'h01, 0);
    bus.in_valid = 1'b0;
    chk("ovr_err", 32'(bus.err), 32'd1);
    chk("ovr_ready", 32'(bus.in_ready), 32'd0);
    chk("ovr_hold", 32'(bus.cpu_hold), 32'd1);
    offer_ignored(8'hAA, 8);
    chk("ovr_err_sticky", 32'(bus.err), 32'd1);
    chk("ovr_done", 32'(bus.done), 32'd0);
    chk("ovr_writes", 32'(n_writes), 32'd0);

    // Full image, word k = k
    do_reset();
    send(8'h04, 0);
    send(8'h00, 0);
    for (int k = 0; k < 1024; k++) begin
      send(8'h00, 0);
      send(8'h00, 0);
      send(8'(k >> 8), 0);
      send(8'(k), 0);
    end
    bus.in_valid = 1'b0;
    chk("full_waddr_last", 32'(bus.waddr), 32'd1023);
    chk("full_wpc_last", bus.wpc, 32'h0000_3FFC);
    chk("full_wdata_last", bus.wdata, 32'h0000_03FF);
    @(negedge clk);
    chk("full_done", 32'(bus.done), 32'd1);
    chk("full_writes", 32'(n_writes), 32'd1024);

    // Reset in the middle of word 1, then a fresh one-word image
    do_reset();
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'h11, 0);
    send(8'h22, 0);
    send(8'h33, 0);
    send(8'h44, 0);
    send(8'h55, 0);
    send(8'h66, 0);
    bus.in_valid = 1'b0;
    do_reset();
    send(8'h00, 0);
    send(8'h01, 0);
    send(8'hDE, 0);
    send(8'hAD, 0);
    send(8'hBE, 0);
    send(8'hEF, 0);
    bus.in_valid = 1'b0;
    chk("mid_waddr", 32'(bus.waddr), 32'd0);
    chk("mid_wdata", bus.wdata, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("mid_done", 32'(bus.done), 32'd1);
    chk("mid_writes", 32'(n_writes), 32'd1);
    chk("mid_queue_empty", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
